// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate generator.
//   imm_fmt_e   : 3-bit immediate format code
//   OP_*        : RV major opcodes recognised by the auto decoder
//   imm_entry_t : decoded result {imm, fmt, illegal} carried through the pipe
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I    = 3'b000,
        FMT_S    = 3'b001,
        FMT_B    = 3'b010,
        FMT_J    = 3'b011,
        FMT_U    = 3'b100,
        FMT_Z    = 3'b101,
        FMT_SH   = 3'b110,
        FMT_NONE = 3'b111
    } imm_fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Entries always carry the widest immediate; narrower instances use the low bits.
    localparam int IMM_W = 64;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        imm_fmt_e         fmt;
        logic             illegal;
    } imm_entry_t;

    localparam imm_entry_t ENTRY_RESET = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};

    // Sign-extend a 32-bit signed value to the entry width.
    function automatic logic signed [IMM_W-1:0] sext_imm(input logic signed [31:0] v);
        return {{(IMM_W-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode_comb: purely combinational instruction -> immediate entry.
//   instr   in  32  raw instruction word
//   imm_src in  3   external format select (only used when AUTO_DECODE=0)
//   entry   out     {imm (sign/zero extended), fmt applied, illegal}
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 1
) (
    input  logic [31:0] instr,
    input  logic [2:0]  imm_src,
    output imm_entry_t  entry
);

    logic [6:0]              opcode;
    logic [2:0]              funct3;
    imm_fmt_e                fmt;
    logic                    illegal;
    logic signed [IMM_W-1:0] ext;
    logic                    unused_src;

    assign opcode     = instr[6:0];
    assign funct3     = instr[14:12];
    assign unused_src = ^imm_src;

    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        if (AUTO_DECODE != 0) begin
            case (opcode)
                OP_LOAD, OP_JALR:  fmt = FMT_I;
                OP_STORE:          fmt = FMT_S;
                OP_BRANCH:         fmt = FMT_B;
                OP_JAL:            fmt = FMT_J;
                OP_LUI, OP_AUIPC:  fmt = FMT_U;
                OP_OP:             fmt = FMT_NONE;
                // Shift-immediates carry shamt, not a 12-bit immediate.
                OP_OPIMM:          fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
                // CSR*I forms (funct3[2]=1) use the rs1 field as a zero-extended uimm.
                OP_SYSTEM:         fmt = funct3[2] ? FMT_Z : FMT_I;
                default: begin
                    fmt     = FMT_NONE;
                    illegal = 1'b1;
                end
            endcase
        end else begin
            fmt = imm_fmt_e'(imm_src);
        end
    end

    always_comb begin
        ext = '0;
        case (fmt)
            FMT_I:  ext = sext_imm({{20{instr[31]}}, instr[31:20]});
            FMT_S:  ext = sext_imm({{20{instr[31]}}, instr[31:25], instr[11:7]});
            FMT_B:  ext = sext_imm({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
            FMT_J:  ext = sext_imm({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
            // U extends from bit 31 so RV64 LUI/AUIPC produce the architected value.
            FMT_U:  ext = sext_imm({instr[31:12], 12'b0});
            FMT_Z:  ext = {{(IMM_W-5){1'b0}}, instr[19:15]};
            FMT_SH: ext = (XLEN == 64) ? {{(IMM_W-6){1'b0}}, instr[25:20]}
                                       : {{(IMM_W-5){1'b0}}, instr[24:20]};
            default: ext = '0;
        endcase
    end

    always_comb begin
        entry         = ENTRY_RESET;
        entry.imm     = ext;
        entry.fmt     = fmt;
        entry.illegal = illegal;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with valid/ready handshake and
// a one-entry skid buffer behind the output register.
//   clk, reset               rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        input handshake (in_ready is a pure register output)
//   in_instr, in_imm_src     instruction word and external format select
//   out_valid/out_ready      output handshake; out_* held while stalled
//   out_imm, out_fmt         extended immediate and the format applied
//   out_illegal              opcode missing from the decode table
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    imm_entry_t dec;
    imm_entry_t main_d, main_q;
    imm_entry_t skid_d, skid_q;
    logic       main_vld_d, main_vld_q;
    logic       skid_vld_d, skid_vld_q;
    logic       accept;
    logic       drain;

    imm_decode_comb #(
        .XLEN        (XLEN),
        .AUTO_DECODE (AUTO_DECODE)
    ) u_decode (
        .instr   (in_instr),
        .imm_src (in_imm_src),
        .entry   (dec)
    );

    assign in_ready    = !skid_vld_q;
    assign accept      = in_valid && in_ready;
    assign drain       = main_vld_q && out_ready;

    assign out_valid   = main_vld_q;
    assign out_imm     = main_q.imm[XLEN-1:0];
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;

    if (XLEN < IMM_W) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^main_q.imm[IMM_W-1:XLEN];
    end

    // Skid only fills when main is occupied and stalled, and in_ready is low
    // whenever skid is full, so accept and skid-refill never coincide.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (drain) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d     = dec;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld_q) begin
                main_d     = dec;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = dec;
                skid_vld_d = 1'b1;
            end
        end
    end

    // Stage boundary: main (presented) register and skid valid
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= ENTRY_RESET;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    // Skid payload is qualified by skid_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic [2:0]  in_imm_src = 3'b0;
    logic        out_ready = 1'b1;

    logic [2:0]       ir, ov, oill;
    logic [2:0][2:0]  ofmt;
    logic [2:0][63:0] oimm;
    logic [63:0]      imm64;
    logic [31:0]      imm32a, imm32b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instance 0: XLEN=64 auto; 1: XLEN=32 auto; 2: XLEN=32 external format.
    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1)) u_d64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(ov[0]),
        .out_ready(out_ready), .out_imm(imm64), .out_fmt(ofmt[0]), .out_illegal(oill[0]));
    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1)) u_d32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(ov[1]),
        .out_ready(out_ready), .out_imm(imm32a), .out_fmt(ofmt[1]), .out_illegal(oill[1]));
    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0)) u_dx (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(ov[2]),
        .out_ready(out_ready), .out_imm(imm32b), .out_fmt(ofmt[2]), .out_illegal(oill[2]));

    assign oimm[0] = imm64;
    assign oimm[1] = {32'b0, imm32a};
    assign oimm[2] = {32'b0, imm32b};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference decode from the instruction-set rules, using signed arithmetic.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [2:0] src,
                                       input int xlen, input bit auto_d);
        exp_t   r;
        longint v;
        logic [6:0] opc;
        logic [2:0] f3;
        opc = ins[6:0];
        f3  = ins[14:12];
        r.ill = 1'b0;
        if (!auto_d) r.fmt = src;
        else begin
            case (opc)
                7'h03, 7'h67: r.fmt = 3'd0;
                7'h23:        r.fmt = 3'd1;
                7'h63:        r.fmt = 3'd2;
                7'h6F:        r.fmt = 3'd3;
                7'h37, 7'h17: r.fmt = 3'd4;
                7'h33:        r.fmt = 3'd7;
                7'h13:        r.fmt = (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd0;
                7'h73:        r.fmt = f3[2] ? 3'd5 : 3'd0;
                default: begin r.fmt = 3'd7; r.ill = 1'b1; end
            endcase
        end
        case (r.fmt)
            3'd0: v = $signed(ins[31:20]);
            3'd1: v = $signed({ins[31:25], ins[11:7]});
            3'd2: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
            3'd3: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
            3'd4: v = $signed(ins[31:12]) * 4096;
            3'd5: v = longint'(ins[19:15]);
            3'd6: v = (xlen == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
            default: v = 0;
        endcase
        r.imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
        return r;
    endfunction

    // Scoreboard: per-instance FIFO of expected entries, popped on output transfer.
    exp_t        fifo [3][8];
    int          wp [3] = '{0, 0, 0};
    int          rp [3] = '{0, 0, 0};
    bit          hold [3] = '{0, 0, 0};
    logic [63:0] hold_imm [3];
    logic [2:0]  hold_fmt [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                rp[i]   = wp[i];
                hold[i] = 1'b0;
            end else begin
                if (hold[i]) begin
                    check("stall_valid", {63'b0, ov[i]}, 64'd1);
                    check("stall_imm", oimm[i], hold_imm[i]);
                    check("stall_fmt", {61'b0, ofmt[i]}, {61'b0, hold_fmt[i]});
                end
                if (ov[i] && out_ready) begin
                    if (rp[i] == wp[i]) begin
                        check("spurious_out", {63'b0, ov[i]}, 64'd0);
                    end else begin
                        exp_t e;
                        e = fifo[i][rp[i] % 8];
                        rp[i]++;
                        check("sb_imm", oimm[i], e.imm);
                        check("sb_fmt", {61'b0, ofmt[i]}, {61'b0, e.fmt});
                        check("sb_ill", {63'b0, oill[i]}, {63'b0, e.ill});
                    end
                end
                hold[i]     = ov[i] && !out_ready;
                hold_imm[i] = oimm[i];
                hold_fmt[i] = ofmt[i];
                if (in_valid && ir[i]) begin
                    fifo[i][wp[i] % 8] = ref_model(in_instr, in_imm_src,
                                                   (i == 0) ? 64 : 32, i != 2);
                    wp[i]++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11] = '{7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37,
                                  7'h17, 7'h33, 7'h13, 7'h73, 7'h7F};
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 12);
        if (k < 11) w[6:0] = ops[k];
        return w;
    endfunction

    task automatic wait_drained(input string tag);
        int n;
        n = 0;
        while ((rp[0] != wp[0] || rp[1] != wp[1] || rp[2] != wp[2]) && n < 20) begin
            cyc();
            n++;
        end
        check(tag, {32'b0, n < 20}, 64'd1);
    endtask

    logic [31:0] tbl_ins [6] = '{32'hFE112E23, 32'hFE000EE3, 32'h0080006F,
                                 32'h123450B7, 32'h3401D073, 32'h4050D093};
    logic [63:0] tbl_imm [6] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'd8,
                                 64'h0000_0000_1234_5000, 64'd3, 64'd5};
    logic [2:0]  tbl_fmt [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [31:0] bp_ins  [4] = '{32'h00100093, 32'hFE112E23, 32'h0080006F, 32'h123450B7};

    initial begin
        // Reset state
        cyc(); cyc();
        reset = 1'b0;
        #1;
        check("rst_in_ready", {61'b0, ir}, 64'd7);
        check("rst_out_valid", {61'b0, ov}, 64'd0);
        check("rst_imm", oimm[0], 64'd0);
        check("rst_fmt", {61'b0, ofmt[0]}, 64'd7);
        check("rst_ill", {61'b0, oill}, 64'd0);

        // addi x1,x0,-1 on XLEN=64, one cycle latency
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFFF00093;
        cyc();
        in_valid = 1'b0;
        check("addi_valid", {63'b0, ov[0]}, 64'd1);
        check("addi_imm", oimm[0], 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_fmt", {61'b0, ofmt[0]}, 64'd0);
        cyc();

        // Format table on XLEN=64
        for (int t = 0; t < 6; t++) begin
            in_valid = 1'b1; in_instr = tbl_ins[t];
            cyc();
            in_valid = 1'b0;
            check("tbl_valid", {63'b0, ov[0]}, 64'd1);
            check("tbl_imm", oimm[0], tbl_imm[t]);
            check("tbl_fmt", {61'b0, ofmt[0]}, {61'b0, tbl_fmt[t]});
        end
        cyc();

        // Illegal opcode (auto) and external S format
        in_valid = 1'b1; in_instr = 32'hFE000FFF; in_imm_src = 3'b001;
        cyc();
        in_valid = 1'b0;
        check("ill_flag", {63'b0, oill[0]}, 64'd1);
        check("ill_imm", oimm[0], 64'd0);
        check("ill_fmt", {61'b0, ofmt[0]}, 64'd7);
        check("ext_fmt", {61'b0, ofmt[2]}, 64'd1);
        check("ext_ill", {63'b0, oill[2]}, 64'd0);
        check("ext_imm", oimm[2], 64'h0000_0000_FFFF_FFFF);
        cyc();

        // Back-pressure: 4 instructions, output stalled for 3 cycles
        begin
            int n;
            bit acc;
            n = 0;
            out_ready = 1'b0;
            for (int c = 0; c < 40 && n < 4; c++) begin
                if (c == 3) out_ready = 1'b1;
                if (c == 2) check("bp_in_ready_low", {63'b0, ir[0]}, 64'd0);
                in_valid = 1'b1; in_instr = bp_ins[n];
                acc = ir[0];
                cyc();
                if (acc) n++;
            end
            in_valid = 1'b0;
            check("bp_all_accepted", n, 64'd4);
            wait_drained("bp_drain");
        end

        // Throughput: back-to-back, one output every clock
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; in_instr = rand_instr();
            cyc();
            check("tp_valid", {63'b0, ov[0]}, 64'd1);
            check("tp_in_ready", {63'b0, ir[0]}, 64'd1);
        end
        in_valid = 1'b0;
        wait_drained("tp_drain");

        // Randomized traffic with random stalls
        for (int c = 0; c < 400; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            in_instr   = rand_instr();
            in_imm_src = 3'($urandom_range(0, 7));
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_drained("rand_drain");

        // Reset with both entries full
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF00093;
        cyc();
        in_instr = 32'h0080006F;
        cyc();
        check("full_skid", {61'b0, ir}, 64'd0);
        reset = 1'b1; in_instr = 32'h123450B7;
        cyc();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("rst_mid_valid", {61'b0, ov}, 64'd0);
        check("rst_mid_ready", {61'b0, ir}, 64'd7);
        for (int c = 0; c < 5; c++) begin
            cyc();
            check("rst_no_stale", {61'b0, ov}, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
